cpu_exec_ctrl: RTL

//  Execution sequencer for the 8-bit LED CPU. Owns the single-port program BRAM: shares it between an

---
 rtl/cpu_ctrl_pkg.sv | 18 +
 rtl/cpu_exec_ctrl_tick_gen.sv | 34 +++
 rtl/cpu_exec_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU execution sequencer.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        HALT  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        STEP  = 3'd3,
        BREAK = 3'd4
    } exec_state_t;

    localparam int unsigned PC_W_DEF   = 11;
    localparam int unsigned DIV_W      = 24;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned SETTLE_CYC = 2;
    localparam int unsigned SETTLE_W   = 2;

endpackage

// File: rtl/cpu_exec_ctrl_tick_gen.sv
// Free-running divider with synchronous clear; flags the last count of each period.
module exec_tick_gen #(
    parameter int unsigned   W   = 24,
    parameter logic [W-1:0]  DIV = W'(1000)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         last_c;

    assign last_c = (cnt_q == DIV - W'(1));
    assign tick_c = !clr_i && last_c;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i || last_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_exec_ctrl.sv
// Execution sequencer: program BRAM port arbitration (loader vs fetch) and
// CPU clock-enable generation for free-run, single-step, halt and breakpoint.
module cpu_exec_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned       PC_W     = PC_W_DEF,
    parameter logic [DIV_W-1:0]  STEP_DIV = 24'd1000,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_req,
    input  logic                 halt_req,
    input  logic                 step_req,
    input  logic                 bp_en,
    input  logic [PC_W-1:0]      bp_addr,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [PC_W-2:0]      ld_addr,
    input  logic [WORD_W-1:0]    ld_data,
    input  logic                 ld_last,
    input  logic [PC_W-1:0]      cpu_pc,
    output logic                 cpu_ce,
    output logic                 cpu_hold,
    output logic                 mem_we,
    output logic [PC_W-2:0]      mem_addr,
    output logic [WORD_W-1:0]    mem_wdata,
    output logic [2:0]           state_o,
    output logic [CNT_W-1:0]     instr_count
);

    exec_state_t          state_q,     state_d;
    logic                 cpu_ce_q,    cpu_ce_d;
    logic                 cpu_hold_q,  cpu_hold_d;
    logic                 ld_ready_q,  ld_ready_d;
    logic                 mem_we_q,    mem_we_d;
    logic [PC_W-2:0]      mem_addr_q,  mem_addr_d;
    logic [WORD_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]     count_q,     count_d;
    logic                 bp_skip_q,   bp_skip_d;
    logic [SETTLE_W-1:0]  settle_q,    settle_d;
    logic                 tick_c;
    logic                 bp_hit_c;

    // Divider only runs while in RUN, so every RUN entry starts a fresh period.
    exec_tick_gen #(
        .W   (DIV_W),
        .DIV (STEP_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != RUN),
        .tick_c (tick_c)
    );

    assign bp_hit_c = bp_en && (cpu_pc == bp_addr) && !bp_skip_q;

    always_comb begin
        state_d     = state_q;
        cpu_ce_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        count_d     = count_q;
        bp_skip_d   = bp_skip_q;
        settle_d    = '0;

        unique case (state_q)
            HALT, BREAK: begin
                if (halt_req) begin
                    state_d = state_q;
                end else if (step_req) begin
                    state_d = STEP;
                    if (state_q == BREAK) bp_skip_d = 1'b1;
                end else if (run_req) begin
                    state_d = RUN;
                    if (state_q == BREAK) bp_skip_d = 1'b1;
                end else if (ld_valid && state_q == HALT) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (ld_valid && ld_ready_q) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ld_addr;
                    mem_wdata_d = ld_data;
                    if (ld_last) begin
                        state_d = HALT;
                        count_d = '0;
                    end
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (tick_c) begin
                    if (bp_hit_c) begin
                        state_d = BREAK;
                    end else begin
                        cpu_ce_d  = 1'b1;
                        count_d   = count_q + CNT_W'(1);
                        bp_skip_d = 1'b0;
                    end
                end
            end
            STEP: begin
                // Wait for pc -> mem_addr -> BRAM dout before enabling the CPU.
                if (halt_req) begin
                    state_d = HALT;
                end else if (settle_q == SETTLE_W'(SETTLE_CYC)) begin
                    cpu_ce_d  = 1'b1;
                    count_d   = count_q + CNT_W'(1);
                    bp_skip_d = 1'b0;
                    state_d   = HALT;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            default: state_d = HALT;
        endcase

        if (state_q != LOAD) begin
            mem_addr_d = cpu_pc[PC_W-1:1];
        end

        ld_ready_d = (state_d == LOAD);
        cpu_hold_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HALT;
            cpu_ce_q    <= 1'b0;
            cpu_hold_q  <= 1'b1;
            ld_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            count_q     <= '0;
            bp_skip_q   <= 1'b0;
            settle_q    <= '0;
        end else begin
            state_q     <= state_d;
            cpu_ce_q    <= cpu_ce_d;
            cpu_hold_q  <= cpu_hold_d;
            ld_ready_q  <= ld_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
            bp_skip_q   <= bp_skip_d;
            settle_q    <= settle_d;
        end
    end

    assign state_o     = state_q;
    assign cpu_ce      = cpu_ce_q;
    assign cpu_hold    = cpu_hold_q;
    assign ld_ready    = ld_ready_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign instr_count = count_q;

endmodule
